sdu_hex_tx: RTL
===============

SDU_HEX_TX -- requirements
Module: sdu_hex_tx

Interface
REQ-001 Parameter BAUD_DIV, default 10417, SHALL set clock cycles per UART bit (100 MHz / 9600 baud).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be a one-cycle request to transmit word; sampled only in IDLE.
REQ-005 word  input  32  SHALL be the value to print, latched on accepted start.
REQ-006 newline  input  1  SHALL, latched with word, request a trailing CR LF.
REQ-007 busy  output  1  SHALL be high from the cycle after an accepted start until transmission ends.
REQ-008 done  output  1  SHALL pulse high for exactly one cycle when the last stop bit completes.
REQ-009 txd  output  1  SHALL be the UART serial line (8N1, idle high).

Function
REQ-010 Accepted start (start=1, state IDLE) SHALL latch word and newline; start while busy SHALL be ignored with no side effect.
REQ-011 Characters SHALL be sent most-significant nibble first: 8 characters per word.
REQ-012 Nibble to ASCII: 0-9 -> 0x30+n, 10-15 -> 0x41+(n-10) (uppercase only).
REQ-013 If latched newline=1, characters 0x0D then 0x0A SHALL follow the 8 hex characters (10 characters total).
REQ-014 Each character SHALL be framed as: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly BAUD_DIV cycles.
REQ-015 Characters SHALL be back-to-back: the next start bit begins the cycle after the previous stop bit ends, with no idle gap.
REQ-016 Byte-level FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT; transitions IDLE->START_BIT on accepted start; START_BIT->DATA_BITS after BAUD_DIV cycles; DATA_BITS->STOP_BIT after 8 bits; STOP_BIT->START_BIT if characters remain, else ->IDLE.
REQ-017 txd SHALL go low in the cycle after start is accepted (same cycle busy rises).
REQ-018 Total transmission SHALL last exactly 10*BAUD_DIV*N cycles, N = 8 or 10.
REQ-019 On the final STOP_BIT -> IDLE transition, done SHALL be 1 and busy SHALL be 0 in the same cycle; start asserted that cycle SHALL be accepted.
REQ-020 Baud counter SHALL be wide enough for BAUD_DIV-1 and SHALL wrap to 0 at each bit boundary; BAUD_DIV >= 2 SHALL be supported.
REQ-021 txd SHALL be registered (no combinational glitches).

Reset
REQ-022 While rstn=0: state IDLE, txd=1, busy=0, done=0, all counters and latched data cleared.
REQ-023 Reset asserted mid-character SHALL abort the transmission immediately; no done pulse SHALL be emitted; after release the block SHALL accept a new start.

Structure
REQ-024 Shared package sdu_pkg SHALL hold the FSM state type, ASCII constants (0x30, 0x41, CR 0x0D, LF 0x0A), and the nibble-to-ASCII function.
REQ-025 A sub-module sdu_uart_tx_byte (byte in, valid/ready, txd out) SHALL implement REQ-014; sdu_hex_tx SHALL sequence characters into it.

Verification
REQ-026 BAUD_DIV=4, word=0x1234ABCD, newline=0 -> bytes 31 32 33 34 41 42 43 44 decoded; done exactly 320 cycles after start accepted.
REQ-027 BAUD_DIV=4, word=0x0000000F, newline=1 -> bytes 30x7, 46, 0D, 0A; done after 400 cycles.
REQ-028 Start pulsed again 50 cycles into a transmission -> ignored; output identical to single-start run; only one done pulse.
REQ-029 rstn low during 3rd character -> txd=1 within the same cycle, busy=0, no done; new start after release sends a full, correct word.
REQ-030 start held high in the done cycle with word=0xFFFFFFFF -> second transmission begins with no idle gap, bytes 46x8.
REQ-031 Bit-width check: every txd level interval is a multiple of BAUD_DIV cycles; frame bit 0 = 0, bit 9 = 1 for every character.

Source files
------------

// File: rtl/sdu_pkg.sv
// Shared types and ASCII helpers for the hex-over-UART transmitter.
package sdu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } tx_state_e;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int CHARS_HEX = 8;
    localparam int CHARS_NL  = 10;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        if (n < 4'd10) return ASCII_0 + {4'b0000, n};
        else           return ASCII_A + {4'b0000, n} - 8'd10;
    endfunction

endpackage

// File: rtl/sdu_uart_tx_byte.sv
// 8N1 byte serializer. Ready is also raised in the final stop-bit cycle so a
// waiting byte starts on the very next cycle with no idle gap.
module sdu_uart_tx_byte
    import sdu_pkg::*;
#(
    parameter int BAUD_DIV = 10417
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_txd
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    tx_state_e        r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [2:0]       r_bit, w_bit_n;
    logic [7:0]       r_shift, w_shift_n;
    logic             r_txd, w_txd_n;
    logic             w_bit_end;

    assign w_bit_end = (r_cnt == CNT_MAX);
    assign o_txd     = r_txd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_txd   <= w_txd_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = w_bit_end ? '0 : r_cnt + 1'b1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_txd_n   = r_txd;
        o_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                w_cnt_n = '0;
                w_txd_n = 1'b1;
                if (i_valid) begin
                    w_shift_n = i_byte;
                    w_txd_n   = 1'b0;
                    w_state_n = START_BIT;
                end
            end
            START_BIT: begin
                if (w_bit_end) begin
                    w_txd_n   = r_shift[0];
                    w_shift_n = r_shift >> 1;
                    w_bit_n   = '0;
                    w_state_n = DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_txd_n   = 1'b1;
                        w_state_n = STOP_BIT;
                    end else begin
                        w_txd_n   = r_shift[0];
                        w_shift_n = r_shift >> 1;
                        w_bit_n   = r_bit + 3'd1;
                    end
                end
            end
            STOP_BIT: begin
                o_ready = w_bit_end;
                if (w_bit_end) begin
                    if (i_valid) begin
                        w_shift_n = i_byte;
                        w_txd_n   = 1'b0;
                        w_state_n = START_BIT;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/sdu_hex_tx.sv
// Prints a 32-bit word as 8 uppercase hex characters (optionally + CR LF)
// over an 8N1 UART, feeding characters back-to-back into the byte serializer.
module sdu_hex_tx
    import sdu_pkg::*;
#(
    parameter int BAUD_DIV = 10417
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] word,
    input  logic        newline,
    output logic        busy,
    output logic        done,
    output logic        txd
);

    logic [31:0] r_word;
    logic        r_nl;
    logic [3:0]  r_idx;
    logic        r_active;

    logic [3:0]  w_nchars;
    logic [3:0]  w_nib;
    logic [7:0]  w_char;
    logic [7:0]  w_byte;
    logic        w_last;
    logic        w_ready;
    logic        w_done;
    logic        w_accept;
    logic        w_valid;

    // r_idx counts characters already handed to the serializer.
    assign w_nchars = r_nl ? 4'(CHARS_NL) : 4'(CHARS_HEX);
    assign w_last   = r_active && (r_idx == w_nchars);
    // Serializer is in its final stop-bit cycle here, so a new start chains on.
    assign w_done   = w_last && w_ready;
    assign w_accept = start && (!r_active || w_done);
    assign w_valid  = (r_active && !w_last) || w_accept;

    assign w_nib = 4'(r_word >> {3'd7 - r_idx[2:0], 2'b00});

    always_comb begin
        w_char = nib2ascii(w_nib);
        if (r_idx == 4'd8)      w_char = ASCII_CR;
        else if (r_idx == 4'd9) w_char = ASCII_LF;
    end

    assign w_byte = w_accept ? nib2ascii(word[31:28]) : w_char;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_word   <= '0;
            r_nl     <= 1'b0;
            r_idx    <= '0;
            r_active <= 1'b0;
        end else if (w_accept) begin
            r_word   <= word;
            r_nl     <= newline;
            r_idx    <= 4'd1;
            r_active <= 1'b1;
        end else if (w_done) begin
            r_idx    <= '0;
            r_active <= 1'b0;
        end else if (w_valid && w_ready) begin
            r_idx    <= r_idx + 4'd1;
        end
    end

    assign busy = r_active && !w_done;
    assign done = w_done;

    sdu_uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_byte (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (w_valid),
        .i_byte  (w_byte),
        .o_ready (w_ready),
        .o_txd   (txd)
    );

endmodule
